// File: rtl/hdmi_packet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_packet_pkg
// Brief    : Packet header type codes and scheduler state encoding shared by
//            the data-island scheduler. SENT_AVI exists only when
//            PACKET_SCHEDULER_AVI_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SENT_ACR    = 3'd1,
        ST_SENT_INFO   = 3'd2,
        ST_SENT_SAMPLE = 3'd3,
        ST_SENT_NULL   = 3'd4
`ifdef PACKET_SCHEDULER_AVI_EN
        , ST_SENT_AVI  = 3'd5
`endif
    } sched_state_t;

    // The state records the last choice, so the presented header is a pure
    // function of it and is registered for free.
    function automatic logic [7:0] state_to_type(input sched_state_t s);
        logic [7:0] t;
        case (s)
            ST_SENT_ACR:    t = PKT_ACR;
            ST_SENT_INFO:   t = PKT_AUDIO_INFO;
            ST_SENT_SAMPLE: t = PKT_AUDIO_SAMPLE;
`ifdef PACKET_SCHEDULER_AVI_EN
            ST_SENT_AVI:    t = PKT_AVI;
`endif
            default:        t = PKT_NULL;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_scheduler_period_flag.sv
`default_nettype none
// ============================================================================
// Module   : period_flag
// Brief    : Frame-period counter with a sticky "due" flag. The flag is set
//            every PERIOD frame starts and cleared when the packet is sent.
// Revision : 1.0 - initial release
// ============================================================================
module period_flag #(
    parameter int PERIOD = 1
) (
    input  logic clk_pixel,
    input  logic reset,
    input  logic frame_start,
    input  logic clear,
    output logic due
);

    localparam logic [7:0] c_last = 8'(PERIOD - 1);

    logic [7:0] r_ctr;
    logic       r_due;
    logic       w_wrap;

    assign w_wrap = frame_start && (r_ctr == c_last);

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_ctr <= '0;
            r_due <= 1'b1;
        end else begin
            if (frame_start) begin
                r_ctr <= w_wrap ? 8'd0 : r_ctr + 8'd1;
            end
            // A send in the wrap cycle consumes the freshly set flag.
            if (clear) begin
                r_due <= 1'b0;
            end else if (w_wrap) begin
                r_due <= 1'b1;
            end
        end
    end

    // Setting is visible in the same cycle so a coincident decision sees it.
    assign due = r_due | w_wrap;

endmodule
`default_nettype wire

// File: rtl/packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : packet_scheduler
// Brief    : Data-island packet arbiter: ACR > InfoFrame > audio sample > null,
//            with the sample-consume strobe for the audio buffer.
//            Define PACKET_SCHEDULER_AVI_EN to add a per-frame AVI InfoFrame.
// Revision : 1.0 - initial release
// ============================================================================
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int INFOFRAME_PERIOD = 1,
    parameter int ACR_PERIOD       = 1,
    parameter int MIN_SAMPLES      = 1,
    parameter int BIT_WIDTH        = 10
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] cx,
    input  logic [BIT_WIDTH-1:0] cy,
    input  logic                 packet_enable,
    input  logic [6:0]           remaining,
    output logic [7:0]           packet_type,
    output logic                 sample_consume,
    output logic [7:0]           frame_count
);

    localparam logic [6:0] c_min_samples = 7'(MIN_SAMPLES);

    sched_state_t r_state;
    sched_state_t w_state_next;
    logic [7:0]   r_frame_count;
    logic         w_frame_start;
    logic         w_acr_due;
    logic         w_info_due;
    logic         w_clr_acr;
    logic         w_clr_info;

    assign w_frame_start = (cx == '0) && (cy == '0);

    period_flag #(.PERIOD(ACR_PERIOD)) u_acr_flag (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .frame_start (w_frame_start),
        .clear       (w_clr_acr),
        .due         (w_acr_due)
    );

    period_flag #(.PERIOD(INFOFRAME_PERIOD)) u_info_flag (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .frame_start (w_frame_start),
        .clear       (w_clr_info),
        .due         (w_info_due)
    );

`ifdef PACKET_SCHEDULER_AVI_EN
    logic w_avi_due;
    logic w_clr_avi;

    period_flag #(.PERIOD(1)) u_avi_flag (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .frame_start (w_frame_start),
        .clear       (w_clr_avi),
        .due         (w_avi_due)
    );
`endif

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every decision is purely priority-driven; the current state only holds
    // the header between packet_enable pulses.
    always_comb begin
        w_state_next = r_state;
        w_clr_acr    = 1'b0;
        w_clr_info   = 1'b0;
`ifdef PACKET_SCHEDULER_AVI_EN
        w_clr_avi    = 1'b0;
`endif
        if (packet_enable) begin
            if (w_acr_due) begin
                w_state_next = ST_SENT_ACR;
                w_clr_acr    = 1'b1;
            end
`ifdef PACKET_SCHEDULER_AVI_EN
            else if (w_avi_due) begin
                w_state_next = ST_SENT_AVI;
                w_clr_avi    = 1'b1;
            end
`endif
            else if (w_info_due) begin
                w_state_next = ST_SENT_INFO;
                w_clr_info   = 1'b1;
            end else if (remaining >= c_min_samples) begin
                w_state_next = ST_SENT_SAMPLE;
            end else begin
                w_state_next = ST_SENT_NULL;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_frame_start) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign packet_type    = state_to_type(r_state);
    assign frame_count    = r_frame_count;
    // Held off during reset so the buffer is never popped without a send.
    assign sample_consume = packet_enable && !reset && (w_state_next == ST_SENT_SAMPLE);

endmodule
`default_nettype wire

// File: tb/tb_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_scheduler
// Brief    : Randomised scoreboard bench for packet_scheduler against a
//            frame-counting reference model (honours PACKET_SCHEDULER_AVI_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_scheduler;

    localparam int TB_INFO = 2;
    localparam int TB_ACR  = 1;
    localparam int TB_MIN  = 3;
    localparam int TB_BW   = 10;

    logic             clk_pixel = 1'b0;
    logic             reset     = 1'b1;
    logic [TB_BW-1:0] cx        = 10'd5;
    logic [TB_BW-1:0] cy        = 10'd5;
    logic             packet_enable = 1'b0;
    logic [6:0]       remaining = 7'd0;
    logic [7:0]       packet_type;
    logic             sample_consume;
    logic [7:0]       frame_count;

    packet_scheduler #(
        .INFOFRAME_PERIOD (TB_INFO),
        .ACR_PERIOD       (TB_ACR),
        .MIN_SAMPLES      (TB_MIN),
        .BIT_WIDTH        (TB_BW)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .cx             (cx),
        .cy             (cy),
        .packet_enable  (packet_enable),
        .remaining      (remaining),
        .packet_type    (packet_type),
        .sample_consume (sample_consume),
        .frame_count    (frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q_type [$];
    bit         q_cons [$];
    logic [7:0] q_fc   [$];

    // Reference model: frames counted since reset, due flags as booleans.
    int m_frames;
    int m_fc;
    bit m_acr_due;
    bit m_info_due;
    bit m_avi_due;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frames   = 0;
        m_fc       = 0;
        m_acr_due  = 1;
        m_info_due = 1;
        m_avi_due  = 1;
    endtask

    task automatic model_step(input int x, input int y, input bit pe, input int rem);
        logic [7:0] t;
        bit         cons;
        if (x == 0 && y == 0) begin
            m_frames++;
            m_fc = (m_fc + 1) % 256;
            if (m_frames % TB_ACR == 0)  m_acr_due  = 1;
            if (m_frames % TB_INFO == 0) m_info_due = 1;
            m_avi_due = 1;
        end
        cons = 0;
        if (pe) begin
            if (m_acr_due) begin
                t = 8'h01; m_acr_due = 0;
            end
`ifdef PACKET_SCHEDULER_AVI_EN
            else if (m_avi_due) begin
                t = 8'h82; m_avi_due = 0;
            end
`endif
            else if (m_info_due) begin
                t = 8'h84; m_info_due = 0;
            end else if (rem >= TB_MIN) begin
                t = 8'h02; cons = 1;
            end else begin
                t = 8'h00;
            end
            q_type.push_back(t);
        end
        q_cons.push_back(cons);
        q_fc.push_back(8'(m_fc));
    endtask

    task automatic cycle(input int x, input int y, input bit pe, input int rem);
        @(negedge clk_pixel);
        reset         = 1'b0;
        cx            = 10'(x);
        cy            = 10'(y);
        packet_enable = pe;
        remaining     = 7'(rem);
        model_step(x, y, pe, rem);
    endtask

    // Asynchronous reset asserted between clock edges; header must clear at once.
    task automatic do_reset();
        @(negedge clk_pixel);
        reset         = 1'b1;
        packet_enable = 1'b0;
        cx            = 10'd5;
        cy            = 10'd5;
        model_reset();
        q_cons.push_back(0);
        q_fc.push_back(8'd0);
        #1;
        check("reset_packet_type", 32'(packet_type), 32'h00);
        check("reset_frame_count", 32'(frame_count), 32'h00);
    endtask

    task automatic pulses(input int n, input int rem);
        for (int i = 0; i < n; i++) begin
            cycle(3, 1, 1, rem);
            cycle(4, 1, 0, rem);
        end
    endtask

    initial begin : monitor
        logic       pe_seen;
        logic [7:0] e8;
        bit         eb;
        forever begin
            @(negedge clk_pixel);
            #3;
            pe_seen = packet_enable && !reset;
            if (q_cons.size() > 0) begin
                eb = q_cons.pop_front();
                check("sample_consume", 32'(sample_consume), 32'(eb));
            end
            @(posedge clk_pixel);
            #1;
            if (q_fc.size() > 0) begin
                e8 = q_fc.pop_front();
                check("frame_count", 32'(frame_count), 32'(e8));
            end
            if (pe_seen) begin
                if (q_type.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL packet_type: DUT decision with no expected entry at %0t", $time);
                end else begin
                    e8 = q_type.pop_front();
                    check("packet_type", 32'(packet_type), 32'(e8));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        model_reset();
        do_reset();

        // Frame start then four pulses with an empty buffer.
        cycle(0, 0, 0, 0);
        pulses(4, 0);

        // Full buffer: ACR, (InfoFrame when due), then samples.
        cycle(0, 0, 0, 10);
        pulses(5, 10);

        // Four frames; InfoFrame due every second frame, ACR every frame.
        for (int f = 0; f < 4; f++) begin
            cycle(0, 0, 0, 0);
            pulses(3, 0);
        end

        // Decision coinciding with frame start right after an ACR.
        cycle(0, 0, 0, 0);
        pulses(1, 0);
        cycle(0, 0, 1, 0);
        cycle(4, 1, 0, 0);

        // Boundary around MIN_SAMPLES.
        cycle(0, 0, 0, 0);
        pulses(2, TB_MIN);
        pulses(1, TB_MIN - 1);
        pulses(1, TB_MIN);

        // Reset mid-frame right after a sample packet.
        cycle(0, 0, 0, 10);
        pulses(3, 10);
        do_reset();
        pulses(2, 10);

        // Frames with no decisions: flags saturate, frame_count wraps.
        for (int f = 0; f < 260; f++) begin
            cycle(0, 0, 0, 0);
        end
        pulses(3, 0);

        // Randomised traffic, remaining changes freely between pulses.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 900)),
                      ($urandom_range(0, 1) == 0) ? 0 : 2,
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 6)));
            end
        end

        cycle(4, 1, 0, 0);
        cycle(4, 1, 0, 0);
        @(negedge clk_pixel);
        check("pending_expectations", 32'(q_type.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
